// File: rtl/somador_dr_ctrl_if.sv
// Single-rail operand/result handshake between the clocked system and the
// dual-rail adder sequencer: master is the system side, slave is the sequencer.
interface somador_dr_ctrl_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_s;
  logic         out_cout;
  logic         out_err;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_s, out_cout, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_s, out_cout, out_err
  );
endinterface

// File: rtl/somador_dr_ctrl.sv
// Clocked sequencer driving DATA/NULL wavefronts into an N-bit dual-rail adder.
// Optional watchdog: define SOMADOR_TIMEOUT_EN (adds parameter TIMEOUT_CYC).
module somador_dr_ctrl #(
  parameter int N = 4
`ifdef SOMADOR_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  somador_dr_ctrl_if.slave bus,
  output logic [2*N-1:0]   A,
  output logic [2*N-1:0]   B,
  output logic [1:0]       Cin,
  input  logic [2*N-1:0]   S,
  input  logic [1:0]       Cout
);

  typedef enum logic [1:0] {NULLW, IDLE, EVAL} state_t;

  state_t         state;
  logic [2*N-1:0] s_meta, s_sync;
  logic [1:0]     cout_meta, cout_sync;
  logic [2*N+1:0] rails;
  logic           complete, allnull, illegal;
  logic           complete_d, allnull_d;
  logic           done_ok, null_ok;
  logic [N-1:0]   sum_dec;
  logic           accept;
  logic           tmo_hit;

  // Rail pair per bit: low rail set means logical 1, high rail set means logical 0.
  function automatic logic [2*N-1:0] enc(input logic [N-1:0] x);
    logic [2*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[2*i +: 2] = {~x[i], x[i]};
    return r;
  endfunction

  assign rails = {cout_sync, s_sync};

  always_comb begin
    complete = 1'b1;
    allnull  = 1'b1;
    illegal  = 1'b0;
    sum_dec  = '0;
    for (int i = 0; i <= N; i++) begin
      if (rails[2*i +: 2] == 2'b00) complete = 1'b0;
      else                           allnull  = 1'b0;
      if (rails[2*i +: 2] == 2'b11) illegal = 1'b1;
    end
    for (int i = 0; i < N; i++) sum_dec[i] = s_sync[2*i];
  end

  // A wavefront only counts once it has been seen on two consecutive synced samples.
  assign done_ok = complete && complete_d;
  assign null_ok = allnull && allnull_d;

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef SOMADOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

  // Restarts on every state change and after each expiry so NULLW keeps re-arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if ((state == IDLE) || tmo_hit || ((state == NULLW) && null_ok) ||
             ((state == EVAL) && done_ok))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + CW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= NULLW;
      A             <= '0;
      B             <= '0;
      Cin           <= '0;
      s_meta        <= '0;
      s_sync        <= '0;
      cout_meta     <= '0;
      cout_sync     <= '0;
      complete_d    <= 1'b0;
      allnull_d     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_s     <= '0;
      bus.out_cout  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      s_meta     <= S;
      s_sync     <= s_meta;
      cout_meta  <= Cout;
      cout_sync  <= cout_meta;
      complete_d <= complete;
      allnull_d  <= allnull;

      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      case (state)
        NULLW: begin
          if (null_ok) state <= IDLE;
        end
        IDLE: begin
          if (accept) begin
            A     <= enc(bus.in_a);
            B     <= enc(bus.in_b);
            Cin   <= {~bus.in_cin, bus.in_cin};
            state <= EVAL;
          end
        end
        EVAL: begin
          if (done_ok) begin
            bus.out_s     <= sum_dec;
            bus.out_cout  <= cout_sync[0];
            bus.out_err   <= illegal;
            bus.out_valid <= 1'b1;
            A             <= '0;
            B             <= '0;
            Cin           <= '0;
            state         <= NULLW;
          end else if (tmo_hit) begin
            bus.out_s     <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            A             <= '0;
            B             <= '0;
            Cin           <= '0;
            state         <= NULLW;
          end
        end
        default: state <= NULLW;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_dr_ctrl.sv
// Bench for somador_dr_ctrl: 3-cycle dual-rail adder model, scoreboard queue of
// expected results popped whenever the DUT hands a result over.
module tb_somador_dr_ctrl;
  localparam int N = 4;
`ifdef SOMADOR_TIMEOUT_EN
  localparam int TMO = 20;
`endif

  typedef struct {
    logic [3:0] s;
    logic       cout;
    logic       err;
    logic       chk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] A, B, S;
  logic [1:0] Cin, Cout;
  logic       force11 = 1'b0;
  logic       skew = 1'b0;
  logic       stuck = 1'b0;
  logic [9:0] dly [8];
  logic [9:0] rawv;
  int         fullCnt = 0;
  int         testsRun = 0;
  int         failed = 0;
  exp_t       expQ [$];
  exp_t       mon;

  somador_dr_ctrl_if #(.N(N)) bus ();

  somador_dr_ctrl #(
    .N(N)
`ifdef SOMADOR_TIMEOUT_EN
    , .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] encDr(input logic [3:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[2*i]   = x[i];
      r[2*i+1] = ~x[i];
    end
    return r;
  endfunction

  function automatic logic legal(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  // Ideal adder: DATA result only when every input pair carries a legal code.
  function automatic logic [9:0] adderModel(input logic [7:0] a2, input logic [7:0] b2,
                                            input logic [1:0] c2);
    logic [3:0] a, b;
    logic [4:0] sum;
    logic       ok;
    ok = legal(c2);
    for (int i = 0; i < 4; i++) begin
      ok   = ok && legal(a2[2*i +: 2]) && legal(b2[2*i +: 2]);
      a[i] = a2[2*i];
      b[i] = b2[2*i];
    end
    sum = {1'b0, a} + {1'b0, b} + {4'b0, c2[0]};
    if (!ok) return '0;
    return {~sum[4], sum[4], encDr(sum[3:0])};
  endfunction

  function automatic logic allValid(input logic [7:0] s2, input logic [1:0] c2);
    logic ok;
    ok = (c2 != 2'b00);
    for (int i = 0; i < 4; i++) ok = ok && (s2[2*i +: 2] != 2'b00);
    return ok;
  endfunction

  always @(posedge clk) begin
    dly[0] <= adderModel(A, B, Cin);
    for (int i = 1; i < 8; i++) dly[i] <= dly[i-1];
    fullCnt <= allValid(S, Cout) ? fullCnt + 1 : 0;
  end

  always_comb begin
    rawv = dly[2];
    if (skew) rawv[7:6] = dly[7][7:6];
    if (force11 && (rawv[1:0] != 2'b00)) rawv[1:0] = 2'b11;
    if (stuck) rawv = '0;
    S    = rawv[7:0];
    Cout = rawv[9:8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected result", 32'(expQ.size()), 1);
      end else begin
        mon = expQ.pop_front();
        checkOutput("out_err", bus.out_err, mon.err);
        if (mon.chk) begin
          checkOutput("out_s", bus.out_s, mon.s);
          checkOutput("out_cout", bus.out_cout, mon.cout);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic cin,
                               input logic tmo);
    exp_t       e;
    logic [4:0] sum;
    bit         seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.in_ready;
    end
    if (!seen) begin
      checkOutput("in_ready wait", bus.in_ready, 1);
      return;
    end
    sum    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    e.s    = tmo ? 4'h0 : sum[3:0];
    e.cout = tmo ? 1'b0 : sum[4];
    e.err  = tmo | force11;
    e.chk  = !force11;
    expQ.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 4'($urandom);
    bus.in_b     = 4'($urandom);
    bus.in_cin   = 1'($urandom);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 32'(expQ.size()), 0);
  endtask

  task automatic waitValid(output int cyc);
    cyc = 0;
    for (int i = 0; i < 400 && !bus.out_valid; i++) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.out_valid) checkOutput("out_valid wait", bus.out_valid, 1);
  endtask

  initial begin
    int cyc;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset A", A, 0);
    checkOutput("reset B", B, 0);
    checkOutput("reset Cin", Cin, 0);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset out_s", bus.out_s, 0);
    checkOutput("reset out_cout", bus.out_cout, 0);
    checkOutput("reset out_err", bus.out_err, 0);
    checkOutput("reset in_ready", bus.in_ready, 0);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(4'h7, 4'h9, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h3, 4'h4, 1'b0, 1'b0);
    waitDrain();
    for (int k = 0; k < 4; k++) applyStimulus(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    waitDrain();

    // Backpressure: result must sit still and block new operands.
    bus.out_ready = 1'b0;
    applyStimulus(4'h5, 4'h6, 1'b0, 1'b0);
    waitValid(cyc);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("hold out_valid", bus.out_valid, 1);
      checkOutput("hold out_s", bus.out_s, 4'hB);
    end
    checkOutput("in_ready blocked", bus.in_ready, 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    #1 checkOutput("in_ready release", bus.in_ready, 1);
    waitDrain();

    force11 = 1'b1;
    applyStimulus(4'h2, 4'h1, 1'b0, 1'b0);
    waitDrain();
    force11 = 1'b0;

    skew = 1'b1;
    applyStimulus(4'h4, 4'h4, 1'b0, 1'b0);
    waitValid(cyc);
    checkOutput("skew filter", 32'(fullCnt >= 4), 1);
    waitDrain();
    skew = 1'b0;

    // Reset while the adder never completes.
    stuck = 1'b1;
    applyStimulus(4'h6, 4'h5, 1'b1, 1'b0);
    checkOutput("eval A", A, encDr(4'h6));
    checkOutput("eval B", B, encDr(4'h5));
    checkOutput("eval Cin", Cin, 2'b01);
    checkOutput("eval in_ready", bus.in_ready, 0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid reset A", A, 0);
    checkOutput("mid reset B", B, 0);
    checkOutput("mid reset Cin", Cin, 0);
    checkOutput("mid reset out_valid", bus.out_valid, 0);
    expQ.delete();
    stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef SOMADOR_TIMEOUT_EN
    stuck = 1'b1;
    applyStimulus(4'h1, 4'h2, 1'b0, 1'b1);
    waitValid(cyc);
    checkOutput("timeout latency", cyc, TMO);
    waitDrain();
    stuck = 1'b0;
`endif

    applyStimulus(4'h9, 4'h9, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end

endmodule
